// File: rtl/wb_arbiter_if.sv
// Bus bundle between the writeback pipeline / long-latency unit (master side)
// and the register-file write-port arbiter (slave side).
interface wb_arbiter_if;
  logic        RegWriteW_i;
  logic [4:0]  RdW_i;
  logic [31:0] ResultW_i;
  logic        LongValid_i;
  logic [4:0]  LongRd_i;
  logic [31:0] LongData_i;
  logic        LongReady_o;
  logic        RegWrite_o;
  logic [4:0]  Rd_o;
  logic [31:0] WriteData_o;
  logic        StallPipe_o;
  logic [1:0]  Count_o;

  modport slave (
    input  RegWriteW_i, RdW_i, ResultW_i, LongValid_i, LongRd_i, LongData_i,
    output LongReady_o, RegWrite_o, Rd_o, WriteData_o, StallPipe_o, Count_o
  );

  modport master (
    output RegWriteW_i, RdW_i, ResultW_i, LongValid_i, LongRd_i, LongData_i,
    input  LongReady_o, RegWrite_o, Rd_o, WriteData_o, StallPipe_o, Count_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// Shares one register-file write port between the W stage and a long-latency
// unit; long results that lose arbitration wait in a two-entry FIFO.
module wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  wb_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    SRC_IDLE   = 2'd0,
    SRC_PIPE   = 2'd1,
    SRC_HEAD   = 2'd2,
    SRC_BYPASS = 2'd3
  } src_e;

  logic [4:0]  rd_q   [DEPTH];
  logic [4:0]  rd_d   [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [31:0] data_d [DEPTH];
  logic        live_q [DEPTH];
  logic        live_d [DEPTH];
  logic        wptr_q, wptr_d;
  logic        rptr_q, rptr_d;
  logic [1:0]  count_q, count_d;

  src_e        src_s;
  logic        stall_s;
  logic        ready_s;
  logic        pipe_active_s;
  logic        push_s;
  logic        pop_s;
  logic        regwrite_s;
  logic [4:0]  rd_s;
  logic [31:0] wdata_s;

  // Source selection and write-port drive
  always_comb begin
    stall_s       = (count_q == 2'd2);
    ready_s       = (count_q < 2'd2);
    pipe_active_s = bus.RegWriteW_i && (bus.RdW_i != 5'd0) && !stall_s;

    if (stall_s) begin
      src_s = SRC_HEAD;
    end else if (pipe_active_s) begin
      src_s = SRC_PIPE;
    end else if (count_q != 2'd0) begin
      src_s = SRC_HEAD;
    end else if (bus.LongValid_i) begin
      src_s = SRC_BYPASS;
    end else begin
      src_s = SRC_IDLE;
    end

    regwrite_s = 1'b0;
    rd_s       = 5'd0;
    wdata_s    = 32'd0;
    case (src_s)
      SRC_PIPE: begin
        regwrite_s = 1'b1;
        rd_s       = bus.RdW_i;
        wdata_s    = bus.ResultW_i;
      end
      SRC_HEAD: begin
        // Killed or x0 entries still pop, but never reach the register file
        regwrite_s = live_q[rptr_q] && (rd_q[rptr_q] != 5'd0);
        rd_s       = rd_q[rptr_q];
        wdata_s    = data_q[rptr_q];
      end
      SRC_BYPASS: begin
        regwrite_s = (bus.LongRd_i != 5'd0);
        rd_s       = bus.LongRd_i;
        wdata_s    = bus.LongData_i;
      end
      default: begin
        regwrite_s = 1'b0;
        rd_s       = 5'd0;
        wdata_s    = 32'd0;
      end
    endcase

    pop_s  = (src_s == SRC_HEAD);
    push_s = bus.LongValid_i && ready_s && (src_s != SRC_BYPASS);
  end

  // FIFO next-state: kill older matching entries, then push, pop, count
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rd_d[i]   = rd_q[i];
      data_d[i] = data_q[i];
      live_d[i] = live_q[i];
      if ((src_s == SRC_PIPE) && (rd_q[i] == bus.RdW_i)) begin
        live_d[i] = 1'b0;
      end else begin
        live_d[i] = live_q[i];
      end
    end

    wptr_d = wptr_q;
    rptr_d = rptr_q;

    // The push comes after the kill so a same-cycle long result stays live
    if (push_s) begin
      rd_d[wptr_q]   = bus.LongRd_i;
      data_d[wptr_q] = bus.LongData_i;
      live_d[wptr_q] = 1'b1;
      wptr_d         = wptr_q + 1'b1;
    end else begin
      wptr_d = wptr_q;
    end

    if (pop_s) begin
      rptr_d = rptr_q + 1'b1;
    end else begin
      rptr_d = rptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= 5'd0;
        data_q[i] <= 32'd0;
        live_q[i] <= 1'b0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= rd_d[i];
        data_q[i] <= data_d[i];
        live_q[i] <= live_d[i];
      end
    end
  end

  assign bus.LongReady_o = ready_s;
  assign bus.StallPipe_o = stall_s;
  assign bus.Count_o     = count_q;
  assign bus.RegWrite_o  = regwrite_s;
  assign bus.Rd_o        = rd_s;
  assign bus.WriteData_o = wdata_s;

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of queue entries for long-latency results; only the value 2 is supported.
REQ-002 SHALL have ports (clock and reset first):
- clk_i  in  1  clock; rising edge
- rst_ni  in  1  asynchronous active-low reset
- RegWriteW_i  in  1  pipeline writeback request
- RdW_i  in  5  pipeline destination register
- ResultW_i  in  32  pipeline result (output of the W-stage result mux)
- LongValid_i  in  1  long-latency unit result valid
- LongRd_i  in  5  long-latency destination register
- LongData_i  in  32  long-latency result
- LongReady_o  out  1  arbiter can accept a long result
- RegWrite_o  out  1  register-file write enable
- Rd_o  out  5  register-file write address
- WriteData_o  out  32  register-file write data
- StallPipe_o  out  1  freeze the W stage and everything upstream
- Count_o  out  2  queue occupancy
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with clock and reset named clk_i and rst_ni.

Function
REQ-004 SHALL share the single register-file write port between the pipeline W stage and a long-latency unit, using a DEPTH-entry FIFO (Rd, data, live bit per entry).
REQ-005 SHALL drive RegWrite_o, Rd_o and WriteData_o combinationally from current inputs and state, so the write commits at the next rising edge.
REQ-006 SHALL treat the pipeline as "active" when RegWriteW_i=1, RdW_i!=0 and StallPipe_o=0.
REQ-007 SHALL assign the port to one source per cycle, in this priority:
- (a) StallPipe_o=1: FIFO head.
- (b) pipeline active: pipeline.
- (c) FIFO non-empty: FIFO head.
- (d) FIFO empty and LongValid_i=1: direct bypass of the Long inputs.
- (e) otherwise: idle.
REQ-008 SHALL pop the FIFO head when it is granted. RegWrite_o=1 only if the head's live bit is 1 and its Rd!=0; otherwise RegWrite_o=0.
REQ-009 SHALL drive LongReady_o = (Count_o < 2), derived only from registered state.
REQ-010 SHALL push {LongRd_i, LongData_i, live=1} when LongValid_i & LongReady_o and no bypass (d) occurs. A bypassed result is never queued.
REQ-011 SHALL handle push and pop in the same cycle as occupancy unchanged, with FIFO order preserved.
REQ-012 SHALL, on a granted pipeline write, clear the live bit of every queued entry with Rd==RdW_i, because the pipeline write is the younger value. A long result pushed in that same cycle is not killed.
REQ-013 SHALL drive StallPipe_o=1 exactly when Count_o==2 (from registered state). While it is 1, the pipeline inputs are ignored and the pipeline re-presents them after the stall.
REQ-014 SHALL accept and discard long results with LongRd_i=0: push or bypass them normally, with RegWrite_o=0.
REQ-015 SHALL drive RegWrite_o=0, Rd_o=0 and WriteData_o=0 when idle.
REQ-016 SHALL use wrap-around read and write pointers of 1 bit each, plus a 2-bit count. Count SHALL never exceed 2 or underflow below 0.

Reset
REQ-017 SHALL, on rst_ni=0 at any time, asynchronously clear the pointers, count and all live bits. The outputs then read Count_o=0, StallPipe_o=0, LongReady_o=1, RegWrite_o=0.
REQ-018 SHALL discard all queued results when reset is asserted mid-operation; no write of queued data occurs after reset.

Verification
REQ-019 SHALL pass these directed scenarios:
- Bypass: FIFO empty, pipeline idle, LongValid_i=1, LongRd_i=7, LongData_i=0xDEADBEEF -> same cycle RegWrite_o=1, Rd_o=7, WriteData_o=0xDEADBEEF; Count_o stays 0.
- Contention: pipeline writes x3=0x11 while long x4=0x22 is valid -> x3 written; next idle cycle writes x4=0x22; Count_o goes 1 then 0.
- Fill and stall: pipeline continuously active, two long results x5 and x6 -> Count_o=2, StallPipe_o=1, LongReady_o=0; x5 is written; next cycle Count_o=1 and StallPipe_o=0.
- Kill: x9 queued, then pipeline writes x9=0x55 -> later pop of x9 gives RegWrite_o=0; register holds 0x55.
- x0: long result with Rd=0 -> never RegWrite_o=1; pipeline RdW_i=0 lets the FIFO drain that cycle.
- Reset mid-operation: Count_o=2, assert rst_ni=0 -> immediately Count_o=0, StallPipe_o=0, LongReady_o=1; no stale write after release.
